ed2_multi_interval_timer: RTL and testbench

//   NUM_CH independent down-counting interval timers behind one Avalon-MM slave.

---
 rtl/ed2_multi_interval_timer.sv | 206 ++++++++++++++++++++
 tb/tb_ed2_multi_interval_timer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ed2_multi_interval_timer.sv
// ed2_multi_interval_timer
//   NUM_CH independent down-counting interval timers behind one Avalon-MM slave.
//   Each channel has a runtime-writable period, one-shot or continuous mode and
//   a snapshot register. Per-channel interrupts (TO & ITO) are ORed onto irq.
//   Address layout is {channel, reg}; reg = address[2:0].
//   Optional feature macro: ED2_TIMER_PRESCALER_EN adds a 16-bit per-channel
//   prescaler at reg 4. Without it, reg 4 reads 0 and ignores writes.
module ed2_multi_interval_timer #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 32'd49_999_999
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         chipselect,
    input  logic [3+$clog2(NUM_CH)-1:0]  address,
    input  logic                         write_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         irq,
    output logic [NUM_CH-1:0]            irq_vec
);

    localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);

    logic        wr_s;
    logic [31:0] ch_s;
    logic [2:0]  reg_s;
    logic [31:0] ch_rd_s [NUM_CH];
    logic [31:0] rd_mux_s;
    logic [31:0] readdata_r;
    logic        unused_wd_s;

    assign wr_s  = chipselect & ~write_n;
    assign ch_s  = 32'(address >> 3'd3);
    assign reg_s = address[2:0];

    // Narrow configurations ignore the upper write-data bits.
    assign unused_wd_s = ^writedata;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             sel_s;
        logic             wr_stat_s;
        logic             wr_ctrl_s;
        logic             wr_per_s;
        logic             wr_snap_s;
        logic             start_s;
        logic             stop_s;
        logic             ptick_s;
        logic             tick_s;
        logic             tmo_s;
        logic [15:0]      presc_s;
        logic [31:0]      rd_s;
        logic             run_r;
        logic             to_r;
        logic             cont_r;
        logic             ito_r;
        logic             reload_r;
        logic [CNT_W-1:0] period_r;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] snap_r;

        assign sel_s   = wr_s & (ch_s == 32'(i));
        assign start_s = wr_ctrl_s & writedata[2];
        assign stop_s  = wr_ctrl_s & writedata[3];
        assign tick_s  = run_r & ptick_s;
        assign tmo_s   = tick_s & (cnt_r == {CNT_W{1'b0}});

        // Decode this channel's register write strobes
        always_comb begin
            wr_stat_s = 1'b0;
            wr_ctrl_s = 1'b0;
            wr_per_s  = 1'b0;
            wr_snap_s = 1'b0;
            if (sel_s) begin
                case (reg_s)
                    3'd0:    wr_stat_s = 1'b1;
                    3'd1:    wr_ctrl_s = 1'b1;
                    3'd2:    wr_per_s  = 1'b1;
                    3'd3:    wr_snap_s = 1'b1;
                    default: wr_stat_s = 1'b0;
                endcase
            end else begin
                wr_stat_s = 1'b0;
            end
        end

        // Mode bits, run flag (START beats STOP and timeout) and sticky TO
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                run_r  <= 1'b0;
                to_r   <= 1'b0;
                cont_r <= 1'b0;
                ito_r  <= 1'b0;
            end else begin
                if (wr_ctrl_s) begin
                    cont_r <= writedata[1];
                    ito_r  <= writedata[0];
                end
                if (start_s) begin
                    run_r <= 1'b1;
                end else if (wr_per_s || stop_s) begin
                    run_r <= 1'b0;
                end else if (tmo_s && !cont_r) begin
                    run_r <= 1'b0;
                end
                // A timeout in the same cycle as a clear wins so none is lost
                if (tmo_s) begin
                    to_r <= 1'b1;
                end else if (wr_stat_s) begin
                    to_r <= 1'b0;
                end
            end
        end

        // Period register, deferred reload, down-counter and snapshot
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                period_r <= DEF_PERIOD;
                cnt_r    <= DEF_PERIOD;
                snap_r   <= {CNT_W{1'b0}};
                reload_r <= 1'b0;
            end else begin
                reload_r <= wr_per_s;
                if (wr_per_s) begin
                    period_r <= writedata[CNT_W-1:0];
                end
                if (wr_snap_s) begin
                    snap_r <= cnt_r;
                end
                if (reload_r) begin
                    cnt_r <= period_r;
                end else if (tick_s) begin
                    cnt_r <= (cnt_r == {CNT_W{1'b0}}) ? period_r : cnt_r - CNT_W'(1);
                end
            end
        end

`ifdef ED2_TIMER_PRESCALER_EN
        logic        wr_presc_s;
        logic [15:0] presc_r;
        logic [15:0] pcnt_r;

        assign wr_presc_s = sel_s & (reg_s == 3'd4);
        assign ptick_s    = (pcnt_r == presc_r);
        assign presc_s    = presc_r;

        // Prescale divider: one tick every presc_r+1 cycles, restarted by PERIOD/START
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                presc_r <= 16'd0;
                pcnt_r  <= 16'd0;
            end else begin
                if (wr_presc_s) begin
                    presc_r <= writedata[15:0];
                end
                if (wr_per_s || start_s) begin
                    pcnt_r <= 16'd0;
                end else if (run_r) begin
                    pcnt_r <= ptick_s ? 16'd0 : pcnt_r + 16'd1;
                end
            end
        end
`else
        assign ptick_s = 1'b1;
        assign presc_s = 16'd0;
`endif

        // Per-channel read word for the selected register
        always_comb begin
            rd_s = 32'd0;
            case (reg_s)
                3'd0:    rd_s = {30'd0, run_r, to_r};
                3'd1:    rd_s = {30'd0, cont_r, ito_r};
                3'd2:    rd_s = 32'(period_r);
                3'd3:    rd_s = 32'(snap_r);
                3'd4:    rd_s = {16'd0, presc_s};
                default: rd_s = 32'd0;
            endcase
        end

        assign ch_rd_s[i] = rd_s;
        assign irq_vec[i] = to_r & ito_r;
    end

    // Pick the addressed channel's word; channel indices past NUM_CH read zero
    always_comb begin
        rd_mux_s = 32'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            rd_mux_s = rd_mux_s | ((ch_s == 32'(k)) ? ch_rd_s[k] : 32'd0);
        end
    end

    // Read data is registered every cycle, independent of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_mux_s;
        end
    end

    assign readdata = readdata_r;
    assign irq      = |irq_vec;

endmodule

// File: tb/tb_ed2_multi_interval_timer.sv
// Directed self-checking bench for ed2_multi_interval_timer. A second,
// five-channel 8-bit instance makes channel indices 5..7 addressable.
module tb_ed2_multi_interval_timer;

    localparam logic [31:0] DEF_P = 32'h02FA_F07F;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic [4:0]  address = 5'd0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  irq_vec;

    logic        cs5 = 1'b0;
    logic [5:0]  addr5 = 6'd0;
    logic        wn5 = 1'b1;
    logic [31:0] wd5 = 32'd0;
    logic [31:0] rdata5;
    logic        irq5;
    logic [4:0]  ivec5;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ed2_multi_interval_timer u_dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .irq_vec(irq_vec)
    );

    ed2_multi_interval_timer #(.NUM_CH(5), .CNT_W(8), .DEFAULT_PERIOD(32'd200)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .chipselect(cs5), .address(addr5),
        .write_n(wn5), .writedata(wd5), .readdata(rdata5),
        .irq(irq5), .irq_vec(ivec5)
    );

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = 5'(ch * 8 + rg); writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input int ch, input int rg, output logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b1; address = 5'(ch * 8 + rg);
        @(negedge clk);
        d = readdata; chipselect = 1'b0;
    endtask

    task automatic wr5(input int ch, input int rg, input logic [31:0] d);
        cs5 = 1'b1; wn5 = 1'b0; addr5 = 6'(ch * 8 + rg); wd5 = d;
        @(negedge clk);
        cs5 = 1'b0; wn5 = 1'b1;
    endtask

    task automatic rd5(input int ch, input int rg, output logic [31:0] d);
        cs5 = 1'b1; wn5 = 1'b1; addr5 = 6'(ch * 8 + rg);
        @(negedge clk);
        d = rdata5; cs5 = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] e;
        vectors++;
        if (readdata !== 32'd0 || irq !== 1'b0 || irq_vec !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: readdata=%h irq=%b irq_vec=%b, want 0/0/0", readdata, irq, irq_vec);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 8; r++) begin
                rd(c, r, d);
                e = (r == 2) ? DEF_P : 32'd0;
                vectors++;
                if (d !== e) begin
                    errors++;
                    $display("FAIL reset_reg ch%0d reg%0d: got %h want %h", c, r, d, e);
                end
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        wr(0, 2, 32'd9);
        wr(0, 1, 32'h5);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            vectors++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_early cycle %0d: irq=%b want 0", k + 1, irq);
            end
        end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1 || irq_vec !== 4'b0001) begin
            errors++;
            $display("FAIL oneshot_tick10: irq=%b irq_vec=%b want 1/0001", irq, irq_vec);
        end
        rd(0, 0, d);
        vectors++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL oneshot_status: got %h want 00000001", d);
        end
        repeat (3) @(negedge clk);
        wr(0, 3, 32'd0);
        rd(0, 3, d);
        vectors++;
        if (d !== 32'd9) begin
            errors++;
            $display("FAIL oneshot_hold: snap=%0d want 9", d);
        end
        rd(0, 1, d);
        vectors++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL oneshot_ctrl_rd: got %h want 00000001", d);
        end
    endtask

    task automatic test_continuous();
        wr(1, 2, 32'd3);
        wr(1, 1, 32'h7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (irq_vec[1] !== 1'b0) begin
                errors++;
                $display("FAIL cont_first_early %0d: irq_vec[1]=%b want 0", k, irq_vec[1]);
            end
        end
        @(negedge clk);
        vectors++;
        if (irq_vec[1] !== 1'b1) begin
            errors++;
            $display("FAIL cont_first: irq_vec[1]=%b want 1", irq_vec[1]);
        end
        wr(1, 0, 32'd0);
        vectors++;
        if (irq_vec[1] !== 1'b0) begin
            errors++;
            $display("FAIL cont_clear: irq_vec[1]=%b want 0", irq_vec[1]);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (irq_vec[1] !== 1'b0) begin
                errors++;
                $display("FAIL cont_second_early %0d: irq_vec[1]=%b want 0", k, irq_vec[1]);
            end
        end
        @(negedge clk);
        vectors++;
        if (irq_vec[1] !== 1'b1) begin
            errors++;
            $display("FAIL cont_period4: irq_vec[1]=%b want 1", irq_vec[1]);
        end
        repeat (3) @(negedge clk);
        wr(1, 0, 32'd0);
        vectors++;
        if (irq_vec[1] !== 1'b1) begin
            errors++;
            $display("FAIL cont_clear_vs_event: irq_vec[1]=%b want 1", irq_vec[1]);
        end
        wr(1, 0, 32'd0);
        vectors++;
        if (irq_vec[1] !== 1'b0) begin
            errors++;
            $display("FAIL cont_clear_after: irq_vec[1]=%b want 0", irq_vec[1]);
        end
        wr(1, 1, 32'h8);
        wr(1, 0, 32'd0);
    endtask

    task automatic test_snapshot_stop();
        logic [31:0] d;
        wr(2, 2, 32'd100);
        wr(2, 1, 32'h4);
        repeat (43) @(negedge clk);
        wr(2, 3, 32'd0);
        rd(2, 3, d);
        vectors++;
        if (d !== 32'd57) begin
            errors++;
            $display("FAIL snap57: got %0d want 57", d);
        end
        wr(2, 3, 32'd0);
        rd(2, 3, d);
        vectors++;
        if (d !== 32'd55) begin
            errors++;
            $display("FAIL snap_running: got %0d want 55", d);
        end
        wr(2, 1, 32'h8);
        rd(2, 0, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL stop_status: got %h want 00000000", d);
        end
        repeat (5) @(negedge clk);
        wr(2, 3, 32'd0);
        rd(2, 3, d);
        vectors++;
        if (d !== 32'd52) begin
            errors++;
            $display("FAIL stop_hold: got %0d want 52", d);
        end
    endtask

    task automatic test_independence();
        logic [31:0] d;
        wr(0, 0, 32'd0);
        wr(0, 2, 32'd2);
        wr(3, 2, 32'd0);
        wr(3, 1, 32'h7);
        wr(0, 1, 32'h4);
        repeat (6) @(negedge clk);
        vectors++;
        if (irq_vec !== 4'b1000 || irq !== 1'b1) begin
            errors++;
            $display("FAIL indep_vec: irq_vec=%b irq=%b want 1000/1", irq_vec, irq);
        end
        rd(0, 0, d);
        vectors++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL indep_ch0_status: got %h want 00000001", d);
        end
        rd(3, 0, d);
        vectors++;
        if (d !== 32'h3) begin
            errors++;
            $display("FAIL indep_ch3_status: got %h want 00000003", d);
        end
        for (int k = 0; k < 4; k++) begin
            wr(3, 0, 32'd0);
            vectors++;
            if (irq_vec[3] !== 1'b1) begin
                errors++;
                $display("FAIL period0_every_clk %0d: irq_vec[3]=%b want 1", k, irq_vec[3]);
            end
        end
        rd(0, 1, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL indep_ch0_ctrl: got %h want 00000000", d);
        end
        wr(3, 1, 32'h8);
        wr(3, 0, 32'd0);
        wr(0, 0, 32'd0);
        vectors++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL indep_quiet: irq=%b want 0", irq);
        end
    endtask

    task automatic test_reg4_and_unused();
        logic [31:0] d;
`ifdef ED2_TIMER_PRESCALER_EN
        wr(0, 4, 32'd4);
        rd(0, 4, d);
        vectors++;
        if (d !== 32'd4) begin
            errors++;
            $display("FAIL presc_rd: got %h want 00000004", d);
        end
        wr(0, 2, 32'd1);
        wr(0, 1, 32'h5);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            vectors++;
            if (irq_vec[0] !== 1'b0) begin
                errors++;
                $display("FAIL presc_early %0d: irq_vec[0]=%b want 0", k + 1, irq_vec[0]);
            end
        end
        @(negedge clk);
        vectors++;
        if (irq_vec[0] !== 1'b1) begin
            errors++;
            $display("FAIL presc_tick10: irq_vec[0]=%b want 1", irq_vec[0]);
        end
        wr(0, 1, 32'h0);
        wr(0, 0, 32'd0);
        wr(0, 4, 32'd0);
`else
        wr(0, 4, 32'h0000_FFFF);
        rd(0, 4, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reg4_disabled: got %h want 00000000", d);
        end
`endif
        for (int r = 5; r < 8; r++) begin
            wr(1, r, 32'hFFFF_FFFF);
            rd(1, r, d);
            vectors++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL unused_reg%0d: got %h want 00000000", r, d);
            end
        end
        rd(1, 2, d);
        vectors++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL unused_no_side_effect: ch1 period=%h want 00000003", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        wr5(4, 2, 32'hFFFF_FF33);
        rd5(4, 2, d);
        vectors++;
        if (d !== 32'h33) begin
            errors++;
            $display("FAIL narrow_period_ch4: got %h want 00000033", d);
        end
        wr5(5, 2, 32'h11);
        wr5(5, 1, 32'h7);
        wr5(6, 1, 32'h7);
        wr5(7, 3, 32'd0);
        rd5(5, 2, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL oor_read_ch5: got %h want 00000000", d);
        end
        for (int c = 0; c < 4; c++) begin
            rd5(c, 2, d);
            vectors++;
            if (d !== 32'd200) begin
                errors++;
                $display("FAIL oor_period ch%0d: got %0d want 200", c, d);
            end
            rd5(c, 1, d);
            vectors++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL oor_ctrl ch%0d: got %h want 00000000", c, d);
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (ivec5 !== 5'd0 || irq5 !== 1'b0) begin
            errors++;
            $display("FAIL oor_irq: irq_vec=%b irq=%b want 00000/0", ivec5, irq5);
        end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        wr(1, 2, 32'd3);
        wr(1, 1, 32'h7);
        repeat (8) @(negedge clk);
        vectors++;
        if (irq_vec[1] !== 1'b1) begin
            errors++;
            $display("FAIL midcount_pre: irq_vec[1]=%b want 1", irq_vec[1]);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (irq !== 1'b0 || irq_vec !== 4'd0 || readdata !== 32'd0) begin
            errors++;
            $display("FAIL midcount_async: irq=%b irq_vec=%b readdata=%h want 0", irq, irq_vec, readdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rd(1, 2, d);
        vectors++;
        if (d !== DEF_P) begin
            errors++;
            $display("FAIL midcount_period: got %h want %h", d, DEF_P);
        end
        rd(1, 1, d);
        vectors++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL midcount_ctrl: got %h want 00000000", d);
        end
        repeat (10) @(negedge clk);
        rd(1, 0, d);
        vectors++;
        if (d !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL midcount_stopped: status=%h irq=%b want 0/0", d, irq);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_oneshot();
        test_continuous();
        test_snapshot_stop();
        test_independence();
        test_reg4_and_unused();
        test_out_of_range();
        test_reset_midcount();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
